stopwatch_counter: RTL and testbench
====================================

// Module: stopwatch_counter
// PURPOSE
//   Timekeeping core of the LCD stopwatch. Divides clk down to a 1/100 s tick
//   and runs a BCD count MM:SS.CC under start/stop, lap and clear pulses.
//   Feeds the LCD driver stage downstream with six registered BCD digits and
//   a one-cycle update strobe whenever the displayed value changes.
// PARAMETERS
//   CLK_HZ   1_000_000  input clock frequency in Hz
//   TICK_HZ  100        count rate; DIV = CLK_HZ/TICK_HZ, integer, >= 2
// PORTS
//   clk         in   1   system clock, all logic on rising edge
//   rst         in   1   synchronous reset, active-high
//   start_stop  in   1   one-cycle pulse (debounced upstream): run/pause
//   lap         in   1   one-cycle pulse: freeze/unfreeze the display
//   clear       in   1   one-cycle pulse: zero the count (IDLE/PAUSED only)
//   disp_bcd    out  24  {min_t,min_o,sec_t,sec_o,cs_t,cs_o}, 4 b BCD each
//   disp_upd    out  1   one-cycle strobe, high on the cycle disp_bcd changes
//   running     out  1   high in RUNNING or LAP
//   lap_active  out  1   high in LAP
//   wrapped     out  1   one-cycle pulse on 59:59.99 -> 00:00.00 rollover
// BEHAVIOUR
//   Interface: one clock (clk); reset (rst) is synchronous and active-high.
//   Reset: state=IDLE, prescaler=0, count=00:00.00, disp_bcd=0, disp_upd=0,
//     running=0, lap_active=0, wrapped=0. Reset mid-run discards everything.
//   Prescaler: counts 0..DIV-1 only in RUNNING/LAP; tick = (pre==DIV-1) in
//     those states, pre wraps to 0. Held (not cleared) in PAUSED; zeroed by
//     clear and on IDLE.
//   Count: on tick, cs_o++ with BCD carries: cs 00-99, sec 00-59, min 00-59.
//     59:59.99 + tick -> 00:00.00, wrapped=1 that cycle, keeps running.
//     Digits never leave the legal range (min_t,sec_t <= 5).
//   FSM (states IDLE, RUNNING, PAUSED, LAP); events evaluated per cycle,
//     priority clear > start_stop > lap; at most one event acts per cycle:
//     IDLE:    start_stop -> RUNNING; lap, clear ignored.
//     RUNNING: start_stop -> PAUSED; lap -> LAP (display frozen at current
//              count); clear ignored.
//     LAP:     start_stop -> PAUSED (display jumps to live count);
//              lap -> RUNNING (display resumes live); clear ignored.
//     PAUSED:  start_stop -> RUNNING; clear -> IDLE (count, pre zeroed);
//              lap ignored.
//   A tick coinciding with start_stop in RUNNING/LAP is still counted.
//   Display: disp_bcd is a register. Not in LAP: loaded with the next count
//     value on the same edge the count updates (zero added latency vs count).
//     In LAP: holds frozen value; count keeps advancing internally.
//   disp_upd = 1 for exactly the cycle after any edge where disp_bcd's value
//     changed (tick, lap release, LAP->PAUSED jump, clear); never otherwise.
//   running/lap_active registered, asserted the cycle after the state change.
// TESTING (sim with CLK_HZ=1000, TICK_HZ=100 -> DIV=10)
//   rst 2 cycles, start_stop, run 1000 clk -> disp_bcd=00:01.00, 100 upd pulses.
//   Preload path: run to 00:59.99, one more tick -> 01:00.00 (sec/cs carries).
//   Run 59:59.99 + 10 clk -> 00:00.00, wrapped pulse 1 cycle, running=1.
//   lap at 00:00.50, wait 200 clk -> disp frozen 00:00.50, no upd; lap again
//     -> disp=00:00.70, upd once, lap_active=0.
//   Pause at pre=4, wait 50 clk, resume -> next tick after 5 more clk; clear in
//     RUNNING ignored; clear in PAUSED -> 00:00.00, IDLE, upd once.
//   start_stop and clear same cycle in PAUSED -> clear wins, IDLE; rst mid-run
//     -> all outputs zero next cycle.

Source files
------------

// File: rtl/stopwatch_counter.sv
// rtl/stopwatch_counter.sv - MM:SS.CC BCD stopwatch core with prescaler, run/pause/lap/clear FSM and display register
module stopwatch_counter #(
    parameter int CLK_HZ  = 1_000_000,
    parameter int TICK_HZ = 100
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        start_stop,
    input  logic        lap,
    input  logic        clear,
    output logic [23:0] disp_bcd,
    output logic        disp_upd,
    output logic        running,
    output logic        lap_active,
    output logic        wrapped
);
    localparam int DIV = CLK_HZ / TICK_HZ;
    localparam int PW  = (DIV > 1) ? $clog2(DIV) : 1;
    localparam logic [PW-1:0] PRE_MAX = PW'(DIV - 1);
    localparam logic [23:0]   COUNT_MAX = 24'h595999;

    typedef enum logic [1:0] {IDLE, RUNNING, PAUSED, LAP} state_t;

    state_t        state, state_next;
    logic [PW-1:0] pre, pre_next;
    logic [23:0]   count, count_next, disp_next;
    logic          active, tick, do_clear;

    // Digit limits from least to most significant: cs_o, cs_t, sec_o, sec_t, min_o, min_t.
    function automatic logic [23:0] bcd_inc(input logic [23:0] c);
        logic [23:0] r;
        logic [3:0]  lim;
        logic        carry;
        r     = c;
        carry = 1'b1;
        for (int i = 0; i < 6; i++) begin
            lim = (i == 3 || i == 5) ? 4'd5 : 4'd9;
            if (carry) begin
                if (r[4*i +: 4] == lim) begin
                    r[4*i +: 4] = 4'd0;
                end else begin
                    r[4*i +: 4] = r[4*i +: 4] + 4'd1;
                    carry       = 1'b0;
                end
            end
        end
        return r;
    endfunction

    always_comb begin
        state_next = state;
        active     = (state == RUNNING) || (state == LAP);
        tick       = active && (pre == PRE_MAX);
        do_clear   = (state == PAUSED) && clear;

        unique case (state)
            IDLE:    if (start_stop) state_next = RUNNING;
            RUNNING: if (start_stop) state_next = PAUSED;
                     else if (lap)   state_next = LAP;
            LAP:     if (start_stop) state_next = PAUSED;
                     else if (lap)   state_next = RUNNING;
            PAUSED:  if (clear)      state_next = IDLE;
                     else if (start_stop) state_next = RUNNING;
        endcase

        pre_next   = pre;
        count_next = count;
        if (do_clear || state == IDLE) begin
            pre_next   = '0;
            count_next = '0;
        end else if (active) begin
            pre_next = tick ? '0 : pre + 1'b1;
            if (tick) count_next = bcd_inc(count);
        end

        // Entering or staying in LAP keeps the display frozen; any other state shows the live count.
        disp_next = (state_next == LAP) ? disp_bcd : count_next;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state      <= IDLE;
            pre        <= '0;
            count      <= '0;
            disp_bcd   <= '0;
            disp_upd   <= 1'b0;
            running    <= 1'b0;
            lap_active <= 1'b0;
            wrapped    <= 1'b0;
        end else begin
            state      <= state_next;
            pre        <= pre_next;
            count      <= count_next;
            disp_bcd   <= disp_next;
            disp_upd   <= (disp_next != disp_bcd);
            running    <= (state_next == RUNNING) || (state_next == LAP);
            lap_active <= (state_next == LAP);
            wrapped    <= tick && (count == COUNT_MAX);
        end
    end
endmodule

// File: tb/tb_stopwatch_counter.sv
// tb/tb_stopwatch_counter.sv - scoreboard bench for stopwatch_counter against a centisecond reference model
module tb_stopwatch_counter;
    localparam int DIV   = 10;
    localparam int WRAP  = 360000;
    localparam int S_IDLE = 0, S_RUN = 1, S_PAUSE = 2, S_LAP = 3;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        start_stop = 1'b0;
    logic        lap = 1'b0;
    logic        clear = 1'b0;
    logic [23:0] disp_bcd;
    logic        disp_upd, running, lap_active, wrapped;

    stopwatch_counter #(.CLK_HZ(1000), .TICK_HZ(100)) dut (
        .clk(clk), .rst(rst), .start_stop(start_stop), .lap(lap), .clear(clear),
        .disp_bcd(disp_bcd), .disp_upd(disp_upd), .running(running),
        .lap_active(lap_active), .wrapped(wrapped)
    );

    always #5 clk = ~clk;

    int          n_chk = 0, n_fail = 0, n_upd = 0, n_wrap = 0;
    int          m_st = S_IDLE, m_pre = 0, m_cs = 0, m_disp = 0;
    logic        e_run = 1'b0, e_lap = 1'b0, e_wrap = 1'b0, mon_en = 1'b0;
    logic [23:0] exp_q[$];

    function automatic logic [23:0] to_bcd(input int cs);
        int m, s, c;
        m = cs / 6000;
        s = (cs / 100) % 60;
        c = cs % 100;
        return {4'(m / 10), 4'(m % 10), 4'(s / 10), 4'(s % 10), 4'(c / 10), 4'(c % 10)};
    endfunction

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
        end
    endtask

    // One clock: drive inputs at the falling edge, advance the model, return just after the rising edge.
    task automatic step(input logic ss, input logic lp, input logic cl, input logic r);
        bit act, tk;
        int nst;
        @(negedge clk);
        rst = r; start_stop = ss; lap = lp; clear = cl; mon_en = 1'b1;
        if (r) begin
            m_st = S_IDLE; m_pre = 0; m_cs = 0; m_disp = 0;
            e_run = 1'b0; e_lap = 1'b0; e_wrap = 1'b0;
            exp_q.delete();
        end else begin
            act = (m_st == S_RUN) || (m_st == S_LAP);
            tk  = act && (m_pre == DIV - 1);
            nst = m_st;
            case (m_st)
                S_IDLE:  if (ss) nst = S_RUN;
                S_RUN:   if (ss) nst = S_PAUSE; else if (lp) nst = S_LAP;
                S_LAP:   if (ss) nst = S_PAUSE; else if (lp) nst = S_RUN;
                default: if (cl) nst = S_IDLE;  else if (ss) nst = S_RUN;
            endcase
            e_wrap = tk && (m_cs == WRAP - 1);
            if (m_st == S_PAUSE && cl) begin
                m_cs = 0; m_pre = 0;
            end else begin
                if (act) m_pre = tk ? 0 : m_pre + 1;
                else if (m_st == S_IDLE) m_pre = 0;
                if (tk) m_cs = (m_cs + 1) % WRAP;
            end
            if (nst != S_LAP && m_cs != m_disp) begin
                m_disp = m_cs;
                exp_q.push_back(to_bcd(m_cs));
            end
            m_st  = nst;
            e_run = (nst == S_RUN) || (nst == S_LAP);
            e_lap = (nst == S_LAP);
        end
        @(posedge clk);
        #2;
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) step(1'b0, 1'b0, 1'b0, 1'b0);
    endtask

    task automatic preload(input int cs);
        dut.count = to_bcd(cs);
        m_cs = cs;
    endtask

    always @(posedge clk) begin
        #1;
        if (mon_en) begin
            if (disp_upd) begin
                n_upd++;
                if (exp_q.size() == 0) chk("disp_upd_spurious", 32'(disp_upd), 32'd0);
                else chk("disp_upd_value", 32'(disp_bcd), 32'(exp_q.pop_front()));
            end else if (exp_q.size() != 0) begin
                chk("disp_upd_missing", 32'(disp_upd), 32'd1);
                exp_q.delete();
            end
            if (wrapped) n_wrap++;
            chk("running", 32'(running), 32'(e_run));
            chk("lap_active", 32'(lap_active), 32'(e_lap));
            chk("wrapped", 32'(wrapped), 32'(e_wrap));
            chk("disp_bcd", 32'(disp_bcd), 32'(to_bcd(m_disp)));
        end
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int u0, w0, cs0, ev;
        step(0, 0, 0, 1);
        step(0, 0, 0, 1);
        chk("reset_disp", 32'(disp_bcd), 32'h0);
        chk("reset_running", 32'(running), 32'd0);

        // 1000 clocks of running gives exactly one second.
        u0 = n_upd;
        step(1, 0, 0, 0);
        idle(1000);
        chk("one_second_disp", 32'(disp_bcd), 32'h000100);
        chk("one_second_upd_count", 32'(n_upd - u0), 32'd100);

        preload(5999);
        idle(DIV);
        chk("carry_to_minute", 32'(disp_bcd), 32'h010000);

        w0 = n_wrap;
        preload(WRAP - 1);
        idle(DIV);
        chk("wrap_disp", 32'(disp_bcd), 32'h000000);
        chk("wrap_pulse_count", 32'(n_wrap - w0), 32'd1);
        chk("wrap_still_running", 32'(running), 32'd1);

        // Lap freeze at 00:00.50 for 200 clocks, then release to live 00:00.70.
        step(0, 0, 0, 1);
        step(1, 0, 0, 0);
        idle(500);
        chk("lap_pre_disp", 32'(disp_bcd), 32'h000050);
        u0 = n_upd;
        step(0, 1, 0, 0);
        idle(199);
        chk("lap_frozen_disp", 32'(disp_bcd), 32'h000050);
        chk("lap_frozen_no_upd", 32'(n_upd - u0), 32'd0);
        chk("lap_active_on", 32'(lap_active), 32'd1);
        step(0, 1, 0, 0);
        chk("lap_release_disp", 32'(disp_bcd), 32'h000070);
        chk("lap_release_upd", 32'(n_upd - u0), 32'd1);
        chk("lap_active_off", 32'(lap_active), 32'd0);

        // Pause with the prescaler at 4; it resumes from 5.
        for (int i = 0; i < 2 * DIV && m_pre != 4; i++) idle(1);
        step(1, 0, 0, 0);
        idle(50);
        cs0 = m_cs;
        step(1, 0, 0, 0);
        idle(4);
        chk("resume_no_early_tick", 32'(disp_bcd), 32'(to_bcd(cs0)));
        idle(1);
        chk("resume_tick_after_5", 32'(disp_bcd), 32'(to_bcd(cs0 + 1)));

        step(0, 0, 1, 0);
        chk("clear_ignored_running", 32'(running), 32'd1);
        step(1, 0, 0, 0);
        u0 = n_upd;
        step(0, 0, 1, 0);
        chk("clear_paused_disp", 32'(disp_bcd), 32'h0);
        chk("clear_paused_upd", 32'(n_upd - u0), 32'd1);
        chk("clear_paused_running", 32'(running), 32'd0);

        step(1, 0, 0, 0);
        idle(23);
        step(1, 0, 0, 0);
        step(1, 0, 1, 0);
        chk("clear_beats_start", 32'(running), 32'd0);
        idle(DIV * 2);
        chk("clear_beats_start_idle", 32'(disp_bcd), 32'h0);

        step(1, 0, 0, 0);
        idle(37);
        step(0, 0, 0, 1);
        chk("rst_midrun_disp", 32'(disp_bcd), 32'h0);
        chk("rst_midrun_upd", 32'(disp_upd), 32'd0);
        chk("rst_midrun_running", 32'(running), 32'd0);

        step(1, 0, 0, 0);
        preload(WRAP - 40);
        for (int i = 0; i < 3000; i++) begin
            ev = int'($urandom_range(0, 99));
            step(ev < 3, ev >= 3 && ev < 6, ev >= 6 && ev < 9, 1'b0);
        end
        idle(3);
        chk("queue_drained", 32'(exp_q.size()), 32'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule
